// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control FSM for the single-issue datapath. Owns the PC, fetches
//   one instruction from a 1-cycle-latency instruction memory, decodes it,
//   issues it to the ALU over a req/ack handshake and then computes the next PC.
//   Sequence per instruction: FETCH -> WAIT -> DECODE -> EXEC -> NEXT.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               1-cycle pulse, leaves IDLE and fetches from PC=0
//   imem_rd_en/addr     instruction memory read strobe and address (=pc)
//   imem_rdata          instruction word, valid the cycle after imem_rd_en
//   alu_req/alu_ack     ALU handshake; alu_req held until alu_ack
//   alu_opcode..jtarget instruction fields presented to the ALU
//   alu_result/taken    ALU outputs, sampled on alu_ack
//   last_result         result of the last retired instruction
//   pc                  current PC
//   busy/halted/err     status: running / halt instruction seen / ALU timeout
//   retired_cnt         (only with INSTR_SEQ_PERF_EN) saturating count of
//                       retired instructions
//
// Build option: define INSTR_SEQ_PERF_EN to add the retired_cnt output.
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_W        = 5,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_rd_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            alu_req,
  input  logic            alu_ack,
  output logic [5:0]      alu_opcode,
  output logic [5:0]      alu_funct,
  output logic [4:0]      alu_rs,
  output logic [4:0]      alu_rt,
  output logic [4:0]      alu_rd,
  output logic [15:0]     alu_imm,
  output logic [25:0]     alu_jtarget,
  input  logic [31:0]     alu_result,
  input  logic            alu_taken,
  output logic [31:0]     last_result,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            err
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [15:0]     retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_NEXT, S_HALT, S_ERR
  } state_t;

  // Value of wait_cnt_reg on the last cycle an ack is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(ALU_TIMEOUT - 1);

  localparam logic [5:0] OP_BEQ  = 6'd10;
  localparam logic [5:0] OP_BNE  = 6'd11;
  localparam logic [5:0] OP_J    = 6'd17;
  localparam logic [5:0] OP_HALT = 6'd63;

  state_t            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   pc_next;
  logic [31:0]       ir_reg;
  logic [31:0]       last_result_reg;
  logic              taken_reg;
  logic [7:0]        wait_cnt_reg;
  logic              rd_en_reg;
  logic              req_reg;
  logic              busy_reg;
  logic              halted_reg;
  logic              err_reg;
  logic [5:0]        opcode_reg;
  logic [5:0]        funct_reg;
  logic [4:0]        rs_reg;
  logic [4:0]        rt_reg;
  logic [4:0]        rd_reg;
  logic [15:0]       imm_reg;
  logic [25:0]       jtarget_reg;
`ifdef INSTR_SEQ_PERF_EN
  logic [15:0]       retired_reg;
`endif

  // Next PC from the fields of the instruction that just executed.
  // Sums are PC_W wide, so wrap from the top of memory to 0 is implicit.
  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    if ((opcode_reg == OP_BEQ || opcode_reg == OP_BNE) && taken_reg) begin
      pc_next = pc_reg + PC_W'(1) + imm_reg[PC_W-1:0];
    end else if (opcode_reg == OP_J) begin
      pc_next = jtarget_reg[PC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pc_reg          <= '0;
      ir_reg          <= '0;
      last_result_reg <= '0;
      taken_reg       <= 1'b0;
      wait_cnt_reg    <= '0;
      rd_en_reg       <= 1'b0;
      req_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      halted_reg      <= 1'b0;
      err_reg         <= 1'b0;
      opcode_reg      <= '0;
      funct_reg       <= '0;
      rs_reg          <= '0;
      rt_reg          <= '0;
      rd_reg          <= '0;
      imm_reg         <= '0;
      jtarget_reg     <= '0;
`ifdef INSTR_SEQ_PERF_EN
      retired_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_FETCH;
            rd_en_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        S_FETCH: begin
          rd_en_reg <= 1'b0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          ir_reg    <= imem_rdata;
          state_reg <= S_DECODE;
        end
        S_DECODE: begin
          if (ir_reg == 32'hFFFF_FFFF || ir_reg[31:26] == OP_HALT) begin
            state_reg  <= S_HALT;
            halted_reg <= 1'b1;
            busy_reg   <= 1'b0;
          end else begin
            opcode_reg   <= ir_reg[31:26];
            funct_reg    <= ir_reg[5:0];
            rs_reg       <= ir_reg[25:21];
            rt_reg       <= ir_reg[20:16];
            rd_reg       <= ir_reg[15:11];
            imm_reg      <= ir_reg[15:0];
            jtarget_reg  <= ir_reg[25:0];
            req_reg      <= 1'b1;
            wait_cnt_reg <= '0;
            state_reg    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Ack wins over timeout when both land in the same cycle.
          if (alu_ack) begin
            last_result_reg <= alu_result;
            taken_reg       <= alu_taken;
            req_reg         <= 1'b0;
            state_reg       <= S_NEXT;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            req_reg   <= 1'b0;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_ERR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        S_NEXT: begin
          pc_reg    <= pc_next;
          rd_en_reg <= 1'b1;
          state_reg <= S_FETCH;
`ifdef INSTR_SEQ_PERF_EN
          if (retired_reg != 16'hFFFF) begin
            retired_reg <= retired_reg + 16'd1;
          end
`endif
        end
        S_HALT, S_ERR: begin
          // Terminal until reset.
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign imem_rd_en  = rd_en_reg;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign alu_req     = req_reg;
  assign alu_opcode  = opcode_reg;
  assign alu_funct   = funct_reg;
  assign alu_rs      = rs_reg;
  assign alu_rt      = rt_reg;
  assign alu_rd      = rd_reg;
  assign alu_imm     = imm_reg;
  assign alu_jtarget = jtarget_reg;
  assign last_result = last_result_reg;
  assign busy        = busy_reg;
  assign halted      = halted_reg;
  assign err         = err_reg;
`ifdef INSTR_SEQ_PERF_EN
  assign retired_cnt = retired_reg;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Directed testbench for instr_sequencer: behavioural instruction memory
//   (1-cycle registered read) and a simple ALU responder with programmable
//   ack delay. Expected values are hand-computed in the stimulus below.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int PC_W = 5;
  localparam int TO   = 15;

  localparam logic [31:0] I_ADDU = 32'h0022_1820; // opcode 0, rs1 rt2 rd3 funct32
  localparam logic [31:0] I_HALT = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic            alu_req;
  logic            alu_ack;
  logic [5:0]      alu_opcode;
  logic [5:0]      alu_funct;
  logic [4:0]      alu_rs;
  logic [4:0]      alu_rt;
  logic [4:0]      alu_rd;
  logic [15:0]     alu_imm;
  logic [25:0]     alu_jtarget;
  logic [31:0]     alu_result = '0;
  logic            alu_taken = 1'b0;
  logic [31:0]     last_result;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            err;
`ifdef INSTR_SEQ_PERF_EN
  logic [15:0]     retired_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [32];

  // ALU responder controls
  logic ack_en    = 1'b1;
  int   ack_delay = 0;
  logic force_ack = 1'b0;
  logic model_ack = 1'b0;
  int   req_cnt   = 0;

  assign alu_ack = model_ack | force_ack;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  // Ack decided on the falling edge so it is stable at the next rising edge.
  always @(negedge clk) begin
    if (alu_req) begin
      model_ack = ack_en && (req_cnt == ack_delay);
      req_cnt   = req_cnt + 1;
    end else begin
      model_ack = 1'b0;
      req_cnt   = 0;
    end
  end

  instr_sequencer #(.PC_W(PC_W), .ALU_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_req(alu_req), .alu_ack(alu_ack),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_rs(alu_rs),
    .alu_rt(alu_rt), .alu_rd(alu_rd), .alu_imm(alu_imm),
    .alu_jtarget(alu_jtarget), .alu_result(alu_result), .alu_taken(alu_taken),
    .last_result(last_result), .pc(pc), .busy(busy), .halted(halted), .err(err)
`ifdef INSTR_SEQ_PERF_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until the next FETCH, then check the PC it fetches from.
  task automatic run_to_fetch(input string tag, input logic [PC_W-1:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (imem_rd_en) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk(tag, 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = I_ADDU;

    // ---- Reset values and basic timing (R-type, ack on first req cycle) ----
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_req", 32'(alu_req), 32'd0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_flags", {30'd0, halted, err}, 32'd0);
`ifdef INSTR_SEQ_PERF_EN
    chk("rst_retired", 32'(retired_cnt), 32'd0);
`endif
    mem[2]  = 32'h4400_0003;  // j 3
    mem[3]  = 32'h2800_0004;  // beq imm 4
    mem[8]  = 32'h47FF_FFE3;  // j, jtarget low bits = 3, upper bits set
    mem[4]  = 32'h4400_001E;  // j 30
    mem[30] = 32'h2800_0005;  // beq imm 5
    alu_result = 32'hA5A5_0001;
    pulse_start();                                   // cycle 1
    chk("c1_rd_en", 32'(imem_rd_en), 32'd1);
    chk("c1_addr", 32'(imem_addr), 32'd0);
    chk("c1_busy", 32'(busy), 32'd1);
    tick();                                          // cycle 2
    chk("c2_rd_en", 32'(imem_rd_en), 32'd0);
    tick();                                          // cycle 3
    chk("c3_req", 32'(alu_req), 32'd0);
    tick();                                          // cycle 4
    chk("c4_req", 32'(alu_req), 32'd1);
    chk("c4_fields", {alu_opcode, alu_funct, alu_rs, alu_rt, alu_rd, 5'd0},
        {6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 5'd0});
    tick();                                          // cycle 5
    chk("c5_req", 32'(alu_req), 32'd0);
    chk("c5_result", last_result, 32'hA5A5_0001);
    tick();                                          // cycle 6
    chk("c6_pc", 32'(pc), 32'd1);
    chk("c6_rd_en", 32'(imem_rd_en), 32'd1);

    // ---- Jumps and branches, including wrap ----
    run_to_fetch("pc1_to_2", 5'd2);
    alu_result = 32'h0000_BEEF;
    run_to_fetch("j3", 5'd3);
    chk("j3_result", last_result, 32'h0000_BEEF);
    alu_taken = 1'b1; ack_delay = 2;
    run_to_fetch("beq_taken", 5'd8);
    alu_taken = 1'b0; ack_delay = 0;
    run_to_fetch("j_trunc", 5'd3);
    run_to_fetch("beq_not_taken", 5'd4);
    run_to_fetch("j30", 5'd30);
    alu_taken = 1'b1;
    run_to_fetch("beq_wrap", 5'd4);
    alu_taken = 1'b0;
    run_to_fetch("j30_again", 5'd30);
    run_to_fetch("beq_nt_31", 5'd31);
    run_to_fetch("wrap_31_0", 5'd0);

    // ---- Jump to halt instruction ----
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = I_ADDU;
    mem[2]  = 32'h4400_0014;  // j 20
    mem[20] = I_HALT;
    pulse_start();
    run_to_fetch("h_pc1", 5'd1);
    run_to_fetch("h_pc2", 5'd2);
    alu_result = 32'hCAFE_0002;
    run_to_fetch("h_j20", 5'd20);
    chk("h_j20_result", last_result, 32'hCAFE_0002);
    begin
      bit req_seen = 1'b0;
      for (int i = 0; i < 20 && !halted; i++) begin
        tick();
        if (alu_req) req_seen = 1'b1;
      end
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_no_req", 32'(req_seen), 32'd0);
    end
    pulse_start();
    tick();
    tick();
    chk("halt_start_ignored", {29'd0, halted, busy, imem_rd_en}, 32'd4);

    // ---- ALU timeout ----
    do_reset();
    ack_en = 1'b0;
    pulse_start();
    tick();
    tick();
    tick();                                          // cycle 4: req rises
    chk("to_req", 32'(alu_req), 32'd1);
    repeat (TO - 1) tick();
    chk("to_err_before", 32'(err), 32'd0);
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", {30'd0, busy, alu_req}, 32'd0);

    // ---- Ack on last allowed cycle ----
    do_reset();
    ack_en = 1'b1; ack_delay = TO - 1;
    alu_result = 32'h0000_5151;
    pulse_start();
    run_to_fetch("late_ack_pc", 5'd1);
    chk("late_ack_err", 32'(err), 32'd0);
    chk("late_ack_result", last_result, 32'h0000_5151);

    // ---- Reset during EXEC; ack after reset ignored ----
    ack_en = 1'b0; ack_delay = 0;
    alu_result = 32'h0000_7777;
    for (int i = 0; i < 10 && !alu_req; i++) tick();
    chk("mid_req", 32'(alu_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out", {27'd0, alu_req, busy, imem_rd_en, halted, err}, 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_fields", {alu_opcode, alu_funct, alu_imm, 4'd0}, 32'd0);
    chk("mid_rst_result", last_result, 32'd0);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    chk("post_rst_ack_result", last_result, 32'd0);
    chk("post_rst_ack_busy", 32'(busy), 32'd0);

`ifdef INSTR_SEQ_PERF_EN
    // ---- Retired count: 10 instructions then halt ----
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = I_ADDU;
    mem[10] = I_HALT;
    ack_en = 1'b1; ack_delay = 0;
    pulse_start();
    for (int i = 0; i < 200 && !halted; i++) tick();
    chk("perf_halted", 32'(halted), 32'd1);
    chk("perf_retired", 32'(retired_cnt), 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
